// File: rtl/fat32_dir_entry_writer_if.sv
// Handshake and sector-buffer bus between the directory-entry writer and its caller.
// The caller (or bench) owns the master side and the sector RAM; the writer owns the slave side.
interface fat32_dir_entry_writer_if #(
    parameter int indexWidth = 9
);
    logic                  start;
    logic [31:0]           startCluster;
    logic [31:0]           fileSize;
    logic [indexWidth-1:0] readAddress;
    logic [7:0]            readByte;
    logic [indexWidth-1:0] writeAddress;
    logic [7:0]            writeByte;
    logic                  writeEnable;
    logic                  busy;
    logic                  done;
    logic                  slotFound;
    logic                  noFreeSlot;
    logic [indexWidth-1:0] entryAddress;

    modport master (
        output start, startCluster, fileSize, readByte,
        input  readAddress, writeAddress, writeByte, writeEnable,
        input  busy, done, slotFound, noFreeSlot, entryAddress
    );

    modport slave (
        input  start, startCluster, fileSize, readByte,
        output readAddress, writeAddress, writeByte, writeEnable,
        output busy, done, slotFound, noFreeSlot, entryAddress
    );
endinterface

// File: rtl/fat32_dir_entry_writer.sv
// Finds a free slot in a loaded root-directory sector and serialises one FAT32
// short-name entry into it, byte by byte, through the buffer write port.
module fat32_dir_entry_writer #(
    parameter int          theSizeofSectors = 512,
    parameter int          indexWidth       = 9,
    parameter logic [87:0] ShortName        = "SAVEDATADAT",
    parameter logic [7:0]  FileAttribute    = 8'h20,
    parameter logic [31:0] FileTimeDate     = 32'h0000_0000
) (
    input  logic                     Clock,
    input  logic                     sys_rst_n,
    fat32_dir_entry_writer_if.slave  bus
);
    localparam int slotCount = theSizeofSectors / 32;
    localparam int slotWidth = indexWidth - 5;
    localparam logic [slotWidth-1:0] lastSlot = slotWidth'(slotCount - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_r, state_s;
    logic [slotWidth-1:0]  slot_r, slot_s;
    logic [4:0]            offset_r, offset_s;
    logic [31:0]           cluster_r, cluster_s;
    logic [31:0]           size_r, size_s;
    logic [indexWidth-1:0] entry_r, entry_s;
    logic [indexWidth-1:0] wa_r, wa_s;
    logic [7:0]            wb_r, wb_s;
    logic                  we_r, we_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  found_r, found_s;
    logic                  nofree_r, nofree_s;
    logic                  free_s;

    // Entry layout: name, attribute, timestamps and the split cluster word, all little-endian.
    function automatic logic [7:0] entry_byte(input logic [4:0] off,
                                              input logic [31:0] clus,
                                              input logic [31:0] sz);
        logic [87:0] name_shift;
        logic [7:0]  b;
        name_shift = ShortName << {off, 3'b000};
        b = 8'h00;
        if (off <= 5'd10) begin
            b = name_shift[87:80];
        end else begin
            case (off)
                5'd11:          b = FileAttribute;
                5'd12, 5'd13:   b = 8'h00;
                5'd14, 5'd22:   b = FileTimeDate[7:0];
                5'd15, 5'd23:   b = FileTimeDate[15:8];
                5'd16, 5'd18,
                5'd24:          b = FileTimeDate[23:16];
                5'd17, 5'd19,
                5'd25:          b = FileTimeDate[31:24];
                5'd20:          b = clus[23:16];
                5'd21:          b = clus[31:24];
                5'd26:          b = clus[7:0];
                5'd27:          b = clus[15:8];
                5'd28:          b = sz[7:0];
                5'd29:          b = sz[15:8];
                5'd30:          b = sz[23:16];
                5'd31:          b = sz[31:24];
                default:        b = 8'h00;
            endcase
        end
        return b;
    endfunction

    assign free_s = (bus.readByte == 8'h00) || (bus.readByte == 8'hE5);

    // State register.
    always_ff @(posedge Clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_s = ST_SCAN;
                else           state_s = ST_IDLE;
            end
            ST_SCAN: begin
                if (free_s)                 state_s = ST_WRITE;
                else if (slot_r == lastSlot) state_s = ST_DONE;
                else                        state_s = ST_SCAN;
            end
            ST_WRITE: begin
                if (offset_r == 5'd31) state_s = ST_DONE;
                else                   state_s = ST_WRITE;
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Output/datapath decode; write port values are prepared one cycle ahead so they leave registered.
    always_comb begin
        slot_s    = slot_r;
        offset_s  = offset_r;
        cluster_s = cluster_r;
        size_s    = size_r;
        entry_s   = entry_r;
        wa_s      = wa_r;
        wb_s      = wb_r;
        we_s      = we_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        found_s   = found_r;
        nofree_s  = nofree_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    cluster_s = bus.startCluster;
                    size_s    = bus.fileSize;
                    slot_s    = '0;
                    found_s   = 1'b0;
                    nofree_s  = 1'b0;
                    busy_s    = 1'b1;
                end else begin
                    busy_s    = busy_r;
                end
            end
            ST_SCAN: begin
                if (free_s) begin
                    entry_s  = {slot_r, 5'd0};
                    offset_s = 5'd0;
                    we_s     = 1'b1;
                    wa_s     = {slot_r, 5'd0};
                    wb_s     = entry_byte(5'd0, cluster_r, size_r);
                end else if (slot_r == lastSlot) begin
                    nofree_s = 1'b1;
                    done_s   = 1'b1;
                end else begin
                    slot_s   = slot_r + 1'b1;
                end
            end
            ST_WRITE: begin
                if (offset_r == 5'd31) begin
                    we_s    = 1'b0;
                    found_s = 1'b1;
                    done_s  = 1'b1;
                end else begin
                    offset_s = offset_r + 5'd1;
                    wa_s     = {slot_r, offset_r + 5'd1};
                    wb_s     = entry_byte(offset_r + 5'd1, cluster_r, size_r);
                end
            end
            ST_DONE: begin
                busy_s = 1'b0;
            end
            default: begin
                we_s   = 1'b0;
                busy_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge Clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            slot_r    <= '0;
            offset_r  <= 5'd0;
            cluster_r <= 32'd0;
            size_r    <= 32'd0;
            entry_r   <= '0;
            wa_r      <= '0;
            wb_r      <= 8'd0;
            we_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            found_r   <= 1'b0;
            nofree_r  <= 1'b0;
        end else begin
            slot_r    <= slot_s;
            offset_r  <= offset_s;
            cluster_r <= cluster_s;
            size_r    <= size_s;
            entry_r   <= entry_s;
            wa_r      <= wa_s;
            wb_r      <= wb_s;
            we_r      <= we_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            found_r   <= found_s;
            nofree_r  <= nofree_s;
        end
    end

    assign bus.readAddress  = {slot_r, 5'd0};
    assign bus.writeAddress = wa_r;
    assign bus.writeByte    = wb_r;
    assign bus.writeEnable  = we_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.slotFound    = found_r;
    assign bus.noFreeSlot   = nofree_r;
    assign bus.entryAddress = entry_r;
endmodule
